// File: rtl/membus_pkg.sv
// -----------------------------------------------------------------------------
// membus_pkg
// Shared definitions for the external-memory bus master:
//   - state_t      : transaction FSM states (IDLE / BUSY / ACK)
//   - DEF_*        : default parameter values for membus_arb
//   - CNT_W        : width of the hung-bus watchdog counter
//   - idx_width()  : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package membus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int DEF_NCH     = 2;
    localparam int DEF_AW      = 27;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 16;

    // A single channel still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority pick. The channel after `last` has the
// highest priority, wrapping modulo NCH.
// Ports:
//   req   [NCH-1:0] in  : per-channel request
//   last  [IW-1:0]  in  : index of the most recently served channel
//   grant [NCH-1:0] out : one-hot winner (all zero when no request)
//   idx   [IW-1:0]  out : index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import membus_pkg::*;
#(
    parameter int  NCH = DEF_NCH,
    localparam int IW  = idx_width(NCH)
)(
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  idx
);

    int   dist_s;
    int   best_s;
    logic take_s;

    // Winner is the requesting channel with the smallest rotated distance from last+1.
    always_comb begin
        grant  = '0;
        idx    = '0;
        best_s = NCH;
        dist_s = 0;
        take_s = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            dist_s = (c + NCH - 1 - int'(last)) % NCH;
            take_s = req[c] && (dist_s < best_s);
            best_s = take_s ? dist_s : best_s;
            idx    = take_s ? IW'(c) : idx;
            grant  = take_s ? (NCH'(1) << c) : grant;
        end
    end

endmodule

// File: rtl/membus_arb.sv
// -----------------------------------------------------------------------------
// membus_arb
// Arbitrates NCH requesters onto one word-addressed external memory port.
// Round-robin fairness; one transaction at a time, minimum 3 cycles each
// (IDLE -> BUSY -> ACK). All outputs are registered.
//
// Optional feature: define MEMBUS_WATCHDOG_EN to abort a BUSY phase that has
// not seen memdone within TIMEOUT cycles; the channel then gets ack and err
// together. Without the macro err is constantly 0 and BUSY waits forever.
//
// Ports:
//   ph1, reset          : clock (rising edge), synchronous active-high reset
//   req/rwb/adr/wdata/byteen : per-channel request, direction, operands
//   ack, err            : one-cycle completion / error pulse to the granted channel
//   rdata               : read data, valid while ack is high (0 for writes/timeouts)
//   memadr/memwdata/membyteen/memrwb/memen : external bus outputs
//   memrdata, memdone   : external read data and completion strobe
// -----------------------------------------------------------------------------
module membus_arb
    import membus_pkg::*;
#(
    parameter int  NCH     = DEF_NCH,
    parameter int  AW      = DEF_AW,
    parameter int  DW      = DEF_DW,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int BW      = DW / 8,
    localparam int IW      = idx_width(NCH)
)(
    input  logic              ph1,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    rwb,
    input  logic [NCH*AW-1:0] adr,
    input  logic [NCH*DW-1:0] wdata,
    input  logic [NCH*BW-1:0] byteen,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    err,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     memadr,
    output logic [DW-1:0]     memwdata,
    input  logic [DW-1:0]     memrdata,
    output logic [BW-1:0]     membyteen,
    output logic              memrwb,
    output logic              memen,
    input  logic              memdone
);

    state_t         state_r;
    logic [IW-1:0]  last_r;
    logic [IW-1:0]  gnt_r;
    logic [NCH-1:0] gnt_oh_r;

    logic [NCH-1:0] arb_grant_s;
    logic [IW-1:0]  arb_idx_s;

    logic [AW-1:0]  sel_adr_s;
    logic [DW-1:0]  sel_wdata_s;
    logic [BW-1:0]  sel_byteen_s;
    logic           sel_rwb_s;

`ifdef MEMBUS_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wd_cnt_r;
`else
    // TIMEOUT only has meaning when the watchdog is compiled in.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req   (req),
        .last  (last_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s)
    );

    // Operand mux: grant is one-hot, so masking and OR-ing selects the winner.
    always_comb begin
        sel_adr_s    = '0;
        sel_wdata_s  = '0;
        sel_byteen_s = '0;
        sel_rwb_s    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            sel_adr_s    = sel_adr_s    | (adr[c*AW +: AW]    & {AW{arb_grant_s[c]}});
            sel_wdata_s  = sel_wdata_s  | (wdata[c*DW +: DW]  & {DW{arb_grant_s[c]}});
            sel_byteen_s = sel_byteen_s | (byteen[c*BW +: BW] & {BW{arb_grant_s[c]}});
            sel_rwb_s    = sel_rwb_s    | (rwb[c] & arb_grant_s[c]);
        end
    end

    // Transaction FSM with all bus and handshake outputs registered.
    always_ff @(posedge ph1) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            last_r    <= IW'(NCH - 1);
            gnt_r     <= '0;
            gnt_oh_r  <= '0;
            ack       <= '0;
            err       <= '0;
            rdata     <= '0;
            memadr    <= '0;
            memwdata  <= '0;
            membyteen <= '0;
            memrwb    <= 1'b1;
            memen     <= 1'b0;
`ifdef MEMBUS_WATCHDOG_EN
            wd_cnt_r  <= '0;
`endif
        end else begin
            // ack/err are single-cycle pulses unless set below.
            ack <= '0;
            err <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        memadr    <= sel_adr_s;
                        memwdata  <= sel_wdata_s;
                        membyteen <= sel_byteen_s;
                        memrwb    <= sel_rwb_s;
                        memen     <= 1'b1;
                        gnt_r     <= arb_idx_s;
                        gnt_oh_r  <= arb_grant_s;
`ifdef MEMBUS_WATCHDOG_EN
                        wd_cnt_r  <= '0;
`endif
                        state_r   <= ST_BUSY;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // memdone on the last permitted cycle still counts as a normal completion.
                    if (memdone) begin
                        rdata   <= memrwb ? memrdata : '0;
                        memen   <= 1'b0;
                        ack     <= gnt_oh_r;
                        state_r <= ST_ACK;
                    end
`ifdef MEMBUS_WATCHDOG_EN
                    else if (wd_cnt_r == WD_LAST) begin
                        rdata   <= '0;
                        memen   <= 1'b0;
                        ack     <= gnt_oh_r;
                        err     <= gnt_oh_r;
                        state_r <= ST_ACK;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CNT_W'(1);
                    end
`else
                    else begin
                        state_r <= ST_BUSY;
                    end
`endif
                end
                ST_ACK: begin
                    last_r  <= gnt_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    memen   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arb.sv
// -----------------------------------------------------------------------------
// tb_membus_arb
// Directed scenarios followed by randomized traffic, checked against a small
// reference model: a set of pending channels, their operands, and the index
// of the last channel served. The next winner is the first pending channel
// found walking upward from last+1, wrapping around.
// -----------------------------------------------------------------------------
module tb_membus_arb;

    localparam int NCH = 2;
    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;

    logic              ph1 = 1'b0;
    logic              reset;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    rwb;
    logic [NCH*AW-1:0] adr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH*BW-1:0] byteen;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    err;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     memadr;
    logic [DW-1:0]     memwdata;
    logic [DW-1:0]     memrdata;
    logic [BW-1:0]     membyteen;
    logic              memrwb;
    logic              memen;
    logic              memdone;

    int total = 0;
    int bad   = 0;

    // reference model
    int            last_m;
    bit            pend   [NCH];
    logic          m_rwb  [NCH];
    logic [AW-1:0] m_adr  [NCH];
    logic [DW-1:0] m_wd   [NCH];
    logic [BW-1:0] m_be   [NCH];

    membus_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .req       (req),
        .rwb       (rwb),
        .adr       (adr),
        .wdata     (wdata),
        .byteen    (byteen),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .memadr    (memadr),
        .memwdata  (memwdata),
        .memrdata  (memrdata),
        .membyteen (membyteen),
        .memrwb    (memrwb),
        .memen     (memen),
        .memdone   (memdone)
    );

    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    task automatic drive_req();
        for (int c = 0; c < NCH; c++) begin
            req[c]              = pend[c];
            rwb[c]              = m_rwb[c];
            adr[c*AW +: AW]     = m_adr[c];
            wdata[c*DW +: DW]   = m_wd[c];
            byteen[c*BW +: BW]  = m_be[c];
        end
    endtask

    task automatic post(input int c, input logic r, input logic [AW-1:0] a,
                        input logic [DW-1:0] w, input logic [BW-1:0] b);
        pend[c]  = 1'b1;
        m_rwb[c] = r;
        m_adr[c] = a;
        m_wd[c]  = w;
        m_be[c]  = b;
        drive_req();
    endtask

    function automatic int pick();
        for (int k = 1; k <= NCH; k++) begin
            if (pend[(last_m + k) % NCH]) return (last_m + k) % NCH;
        end
        return -1;
    endfunction

    // Called with the DUT about to sample requests in IDLE; ends at the same point.
    task automatic run_txn(input int ch, input int busy_wait, input logic [DW-1:0] rd);
        logic [NCH-1:0] exp_oh;
        exp_oh     = '0;
        exp_oh[ch] = 1'b1;
        step();
        chk("grant_memen", 64'(memen), 64'd1);
        chk("memadr", 64'(memadr), 64'(m_adr[ch]));
        chk("memrwb", 64'(memrwb), 64'(m_rwb[ch]));
        chk("memwdata", 64'(memwdata), 64'(m_wd[ch]));
        chk("membyteen", 64'(membyteen), 64'(m_be[ch]));
        chk("ack_in_busy", 64'(ack), 64'd0);
        for (int i = 0; i < busy_wait; i++) begin
            step();
            chk("busy_hold", 64'({memen, ack, err, memadr}),
                64'({1'b1, {NCH{1'b0}}, {NCH{1'b0}}, m_adr[ch]}));
        end
        memdone  = 1'b1;
        memrdata = rd;
        step();
        memdone  = 1'b0;
        memrdata = $urandom();
        chk("ack", 64'(ack), 64'(exp_oh));
        chk("err", 64'(err), 64'd0);
        chk("memen_ack", 64'(memen), 64'd0);
        chk("rdata", 64'(rdata), 64'(m_rwb[ch] ? rd : {DW{1'b0}}));
        pend[ch] = 1'b0;
        last_m   = ch;
        step();
        drive_req();
        chk("ack_clear", 64'({ack, err, memen}), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        rwb      = '0;
        adr      = '0;
        wdata    = '0;
        byteen   = '0;
        memrdata = '0;
        memdone  = 1'b0;
        last_m   = NCH - 1;
        for (int c = 0; c < NCH; c++) begin
            pend[c] = 1'b0; m_rwb[c] = 1'b1; m_adr[c] = '0; m_wd[c] = '0; m_be[c] = '0;
        end

        // reset state
        step();
        step();
        chk("rst_memen", 64'(memen), 64'd0);
        chk("rst_ack_err", 64'({ack, err}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_bus", 64'({memadr, membyteen}), 64'd0);
        chk("rst_memwdata", 64'(memwdata), 64'd0);
        chk("rst_memrwb", 64'(memrwb), 64'd1);
        reset = 1'b0;

        // single read on ch0, memdone after 2 BUSY cycles
        post(0, 1'b1, 27'h10, 32'h0, 4'hf);
        run_txn(0, 2, 32'hDEADBEEF);

        // write with byte enables on ch1
        post(1, 1'b0, 27'h3, 32'h12345678, 4'b0011);
        run_txn(1, 0, 32'hCAFEF00D);

        // fairness: both request continuously, immediate memdone
        post(0, 1'b1, 27'h100, 32'h0, 4'hf);
        post(1, 1'b0, 27'h200, 32'hA5A5A5A5, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            run_txn(i % 2, 0, 32'h1000 + 32'(i));
            post(i % 2, m_rwb[i % 2], m_adr[i % 2], m_wd[i % 2], m_be[i % 2]);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_req();
        step();

`ifdef MEMBUS_WATCHDOG_EN
        // watchdog: no memdone -> ack+err after 4 BUSY cycles
        post(0, 1'b1, 27'h44, 32'h0, 4'hf);
        step();
        chk("wd_memen", 64'(memen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_wait", 64'({memen, ack, err}), 64'({1'b1, {NCH{1'b0}}, {NCH{1'b0}}}));
        end
        step();
        chk("wd_ack", 64'(ack), 64'd1);
        chk("wd_err", 64'(err), 64'd1);
        chk("wd_rdata", 64'(rdata), 64'd0);
        chk("wd_memen_off", 64'(memen), 64'd0);
        pend[0] = 1'b0;
        last_m  = 0;
        step();
        drive_req();
        chk("wd_clear", 64'({ack, err}), 64'd0);
        // memdone on the fourth BUSY cycle completes normally
        post(1, 1'b1, 27'h55, 32'h0, 4'hf);
        run_txn(1, 3, 32'h0BADC0DE);
`else
        // no watchdog: BUSY holds for 1000 cycles without ack or err
        post(0, 1'b1, 27'h44, 32'h0, 4'hf);
        run_txn(0, 1000, 32'h600DF00D);
`endif

        // memdone while IDLE is ignored
        memdone = 1'b1;
        step();
        chk("idle_memdone", 64'({ack, memen}), 64'd0);
        step();
        chk("idle_memdone2", 64'({ack, memen}), 64'd0);
        memdone = 1'b0;

        // reset mid-BUSY: make ch0 the last served, then abort a ch1 transaction
        post(0, 1'b1, 27'h70, 32'h0, 4'hf);
        run_txn(0, 0, 32'h77777777);
        post(1, 1'b0, 27'h71, 32'h11112222, 4'hf);
        step();
        chk("mid_busy_memen", 64'(memen), 64'd1);
        reset   = 1'b1;
        memdone = 1'b1;
        step();
        chk("rst_busy_memen", 64'(memen), 64'd0);
        chk("rst_busy_ack", 64'(ack), 64'd0);
        chk("rst_busy_memrwb", 64'(memrwb), 64'd1);
        reset   = 1'b0;
        memdone = 1'b0;
        last_m  = NCH - 1;
        pend[1] = 1'b0;
        post(0, 1'b1, 27'h80, 32'h0, 4'hf);
        post(1, 1'b1, 27'h81, 32'h0, 4'hf);
        run_txn(0, 1, 32'h80808080);
        run_txn(1, 0, 32'h81818181);

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    post(c, 1'($urandom_range(0, 1)), AW'($urandom()), $urandom(), BW'($urandom()));
                end
            end
            if (pick() < 0) begin
                memdone = 1'($urandom_range(0, 1));
                step();
                memdone = 1'b0;
                chk("rand_idle", 64'({ack, memen}), 64'd0);
            end else begin
                run_txn(pick(), $urandom_range(0, 3), $urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
